// File: rtl/svnet_ram_arb_pkg.sv
// svnet_ram_pkg: shared constants and read-pipeline tag for the svnet_ram_arb slice
package svnet_ram_pkg;
  localparam int SVNET_RAM_W2R_DELAY = 1;
  localparam int SVNET_RAM_R2V_DELAY = 2;
  localparam int SVNET_RAM_CREDITS = 3;
  localparam int SVNET_RAM_WIDTH = 32;
  localparam int SVNET_RAM_DEPTH = 256;
  localparam int SVNET_RAM_LANE_WIDTH = 8;
  localparam int SVNET_RAM_NUM_CH = 4;
  localparam int SVNET_RAM_AW = $clog2(SVNET_RAM_DEPTH);
  localparam int SVNET_RAM_CHW = SVNET_RAM_NUM_CH > 1 ? $clog2(SVNET_RAM_NUM_CH) : 1;
  typedef struct packed {
    logic valid;
    logic [SVNET_RAM_CHW-1:0] ch;
    logic [SVNET_RAM_AW-1:0] addr;
  } rd_tag_t;
endpackage

// File: rtl/svnet_ram_arb_if.sv
// svnet_ram_arb_if: write port, per-channel read requests and credit-backed responses
interface svnet_ram_arb_if
  import svnet_ram_pkg::*;
#(
  parameter int WIDTH = SVNET_RAM_WIDTH,
  parameter int AW = SVNET_RAM_AW,
  parameter int LANES = SVNET_RAM_WIDTH / SVNET_RAM_LANE_WIDTH,
  parameter int NUM_CH = SVNET_RAM_NUM_CH
) ();
  logic wr_valid;
  logic [AW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [LANES-1:0] wr_be;
  logic [NUM_CH-1:0] rd_valid;
  logic [NUM_CH*AW-1:0] rd_addr;
  logic [NUM_CH-1:0] rd_ready;
  logic [NUM_CH-1:0] rsp_valid;
  logic [NUM_CH*WIDTH-1:0] rsp_data;
  logic [NUM_CH-1:0] rsp_ready;
  modport master (
    output wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr, rsp_ready,
    input rd_ready, rsp_valid, rsp_data
  );
  modport slave (
    input wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr, rsp_ready,
    output rd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/svnet_ram_arb_rr_arbiter.sv
// svnet_rr_arbiter: round-robin one-hot grant; pointer moves past the winner, holds when idle
module svnet_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_nxt;
  logic w_hit;
  always_comb begin
    o_gnt = '0;
    w_nxt = r_ptr;
    w_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_hit && i_req[(int'(r_ptr) + i) % N]) begin
        o_gnt[(int'(r_ptr) + i) % N] = 1'b1;
        w_nxt = PW'((int'(r_ptr) + i + 1) % N);
        w_hit = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (w_hit) r_ptr <= w_nxt;
  end
endmodule

// File: rtl/svnet_ram_arb.sv
// svnet_ram_arb: shared RAM, round-robin read channels with 3-credit response FIFOs
// Define SVNET_RAM_ARB_BYPASS_EN to forward a same-cycle write into a colliding read.
module svnet_ram_arb
  import svnet_ram_pkg::*;
#(
  parameter int WIDTH = SVNET_RAM_WIDTH,
  parameter int DEPTH = SVNET_RAM_DEPTH,
  parameter int LANE_WIDTH = SVNET_RAM_LANE_WIDTH,
  parameter int NUM_CH = SVNET_RAM_NUM_CH
) (
  input logic clk,
  input logic rst,
  svnet_ram_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LANES = WIDTH / LANE_WIDTH;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic r_wr_valid;
  logic [AW-1:0] r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic [LANES-1:0] r_wr_be;
  rd_tag_t r_tag;
  logic [1:0] r_cred [NUM_CH];
  logic [1:0] r_cnt [NUM_CH];
  logic [1:0] r_rp [NUM_CH];
  logic [1:0] r_wp [NUM_CH];
  logic [WIDTH-1:0] r_fifo [NUM_CH][3];
  logic [NUM_CH-1:0] w_req, w_gnt, w_pop, w_push;
  logic [SVNET_RAM_CHW-1:0] w_gch;
  logic [AW-1:0] w_gaddr;
  logic [WIDTH-1:0] w_mem_q, w_word;
  svnet_rr_arbiter #(.N(NUM_CH)) u_arb (.clk(clk), .rst(rst), .i_req(w_req), .o_gnt(w_gnt));
  assign bus.rd_ready = w_gnt;
  assign w_gaddr = bus.rd_addr[w_gch*AW +: AW];
  assign w_mem_q = r_mem[r_tag.addr];
  always_comb begin
    w_req = '0;
    w_pop = '0;
    w_push = '0;
    w_gch = '0;
    bus.rsp_valid = '0;
    bus.rsp_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_req[c] = !rst && bus.rd_valid[c] && r_cred[c] != 2'd0;
      w_pop[c] = r_cnt[c] != 2'd0 && bus.rsp_ready[c];
      w_push[c] = r_tag.valid && int'(r_tag.ch) == c;
      w_gch = w_gnt[c] ? SVNET_RAM_CHW'(c) : w_gch;
      bus.rsp_valid[c] = r_cnt[c] != 2'd0;
      bus.rsp_data[c*WIDTH +: WIDTH] = r_cnt[c] != 2'd0 ? r_fifo[c][r_rp[c]] : '0;
    end
  end
  always_comb begin
    w_word = w_mem_q;
`ifdef SVNET_RAM_ARB_BYPASS_EN
    for (int l = 0; l < LANES; l++)
      if (r_wr_valid && r_wr_addr == r_tag.addr && r_wr_be[l])
        w_word[l*LANE_WIDTH +: LANE_WIDTH] = r_wr_data[l*LANE_WIDTH +: LANE_WIDTH];
`endif
  end
  always_ff @(posedge clk) begin
    r_wr_addr <= bus.wr_addr;
    r_wr_data <= bus.wr_data;
    r_wr_be <= bus.wr_be;
    if (rst) begin
      r_wr_valid <= 1'b0;
      r_tag <= '0;
    end else begin
      r_wr_valid <= bus.wr_valid;
      r_tag <= '{valid: |w_gnt, ch: w_gch, addr: w_gaddr};
    end
  end
  // array is intentionally unreset; only enabled lanes are written
  always_ff @(posedge clk) begin
    if (r_wr_valid)
      for (int l = 0; l < LANES; l++)
        if (r_wr_be[l]) r_mem[r_wr_addr][l*LANE_WIDTH +: LANE_WIDTH] <= r_wr_data[l*LANE_WIDTH +: LANE_WIDTH];
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        r_cred[c] <= 2'(SVNET_RAM_CREDITS);
        r_cnt[c] <= 2'd0;
        r_rp[c] <= 2'd0;
        r_wp[c] <= 2'd0;
      end else begin
        if (w_push[c]) begin
          r_fifo[c][r_wp[c]] <= w_word;
          r_wp[c] <= r_wp[c] == 2'd2 ? 2'd0 : r_wp[c] + 2'd1;
        end
        if (w_pop[c]) r_rp[c] <= r_rp[c] == 2'd2 ? 2'd0 : r_rp[c] + 2'd1;
        r_cnt[c] <= r_cnt[c] + 2'(w_push[c]) - 2'(w_pop[c]);
        r_cred[c] <= r_cred[c] - 2'(w_gnt[c]) + 2'(w_pop[c]);
      end
    end
  end
  a_lanes: assert property (@(posedge clk) WIDTH % LANE_WIDTH == 0);
  a_wr_addr: assert property (@(posedge clk) disable iff (rst) bus.wr_valid |-> int'(bus.wr_addr) < DEPTH);
  a_rd_addr: assert property (@(posedge clk) disable iff (rst) |w_gnt |-> int'(w_gaddr) < DEPTH);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ovf
    a_ovf: assert property (@(posedge clk) disable iff (rst) !(w_push[g] && !w_pop[g] && r_cnt[g] == 2'd3));
  end
endmodule

// File: tb/tb_svnet_ram_arb.sv
// tb_svnet_ram_arb: directed scenarios for svnet_ram_arb with hand-computed expectations
module tb_svnet_ram_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q [4][$];
  logic [31:0] exp_q [$];
  svnet_ram_arb_if bus ();
  svnet_ram_arb dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_valid = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_be = be;
    step;
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [7:0] a, output logic [31:0] d, output logic v);
    bus.rd_valid[ch] = 1'b1;
    bus.rd_addr[ch*8 +: 8] = a;
    step;
    bus.rd_valid[ch] = 1'b0;
    bus.wr_valid = 1'b0;
    step;
    mid;
    v = bus.rsp_valid[ch];
    d = bus.rsp_data[ch*32 +: 32];
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.rd_valid = 4'hf;
    mid;
    n_chk++;
    if (bus.rd_ready !== 4'h0) begin n_fail++; $display("FAIL reset_rd_ready got=%h exp=0", bus.rd_ready); end
    n_chk++;
    if (bus.rsp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_valid got=%h exp=0", bus.rsp_valid); end
    n_chk++;
    if (bus.rsp_data !== 128'h0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
    step;
    bus.rd_valid = 4'h0;
    rst = 1'b0;
    step;
  endtask

  task automatic test_write_read;
    wr(8'd5, 32'hA5A5A5A5, 4'hf);
    step;
    bus.rd_valid[0] = 1'b1;
    bus.rd_addr[7:0] = 8'd5;
    mid;
    n_chk++;
    if (bus.rd_ready !== 4'b0001) begin n_fail++; $display("FAIL wr_rd_grant got=%b exp=0001", bus.rd_ready); end
    step;
    bus.rd_valid[0] = 1'b0;
    mid;
    n_chk++;
    if (bus.rsp_valid !== 4'h0) begin n_fail++; $display("FAIL wr_rd_early got=%b exp=0000", bus.rsp_valid); end
    step;
    mid;
    n_chk++;
    if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL wr_rd_valid got=%b exp=0001", bus.rsp_valid); end
    n_chk++;
    if (bus.rsp_data[31:0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wr_rd_data got=%h exp=a5a5a5a5", bus.rsp_data[31:0]); end
    step;
    mid;
    n_chk++;
    if (bus.rsp_valid !== 4'h0) begin n_fail++; $display("FAIL wr_rd_popped got=%b exp=0000", bus.rsp_valid); end
    step;
  endtask

  task automatic test_lane_mask;
    logic [31:0] d;
    logic v;
    wr(8'd7, 32'hFFFFFFFF, 4'hf);
    wr(8'd7, 32'h11223344, 4'b0101);
    rd(0, 8'd7, d, v);
    n_chk++;
    if (v !== 1'b1 || d !== 32'hFF22FF44) begin n_fail++; $display("FAIL lane_mask got=%b/%h exp=1/ff22ff44", v, d); end
  endtask

  task automatic test_same_cycle;
    logic [31:0] d, e;
    logic v;
    wr(8'd9, 32'h0, 4'hf);
    step;
    bus.wr_valid = 1'b1;
    bus.wr_addr = 8'd9;
    bus.wr_data = 32'hDEADBEEF;
    bus.wr_be = 4'hf;
    rd(1, 8'd9, d, v);
`ifdef SVNET_RAM_ARB_BYPASS_EN
    e = 32'hDEADBEEF;
`else
    e = 32'h0;
`endif
    n_chk++;
    if (v !== 1'b1 || d !== e) begin n_fail++; $display("FAIL same_cycle got=%b/%h exp=1/%h", v, d, e); end
    rd(1, 8'd9, d, v);
    n_chk++;
    if (v !== 1'b1 || d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL same_cycle_after got=%b/%h exp=1/deadbeef", v, d); end
  endtask

  task automatic test_w2r;
    logic [31:0] d;
    logic v;
    wr(8'd11, 32'h0, 4'hf);
    wr(8'd11, 32'h12345678, 4'hf);
    rd(3, 8'd11, d, v);
    n_chk++;
    if (v !== 1'b1 || d !== 32'h12345678) begin n_fail++; $display("FAIL w2r got=%b/%h exp=1/12345678", v, d); end
  endtask

  task automatic test_round_robin;
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int a = 20; a < 28; a++) wr(8'(a), 32'h1000 + 32'(a), 4'hf);
    for (int c = 0; c < 4; c++) q[c].delete();
    for (int i = 0; i < 12; i++) begin
      bus.rd_valid = i < 8 ? 4'hf : 4'h0;
      for (int c = 0; c < 4; c++) bus.rd_addr[c*8 +: 8] = 8'(i < 4 ? 20 + c : 24 + c);
      mid;
      if (i < 8) begin
        n_chk++;
        if (bus.rd_ready !== 4'(1 << (i % 4))) begin n_fail++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, bus.rd_ready, 4'(1 << (i % 4))); end
      end
      for (int c = 0; c < 4; c++) if (bus.rsp_valid[c]) q[c].push_back(bus.rsp_data[c*32 +: 32]);
      step;
    end
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if (q[c].size() != 2) begin
        n_fail++;
        $display("FAIL rr_count ch=%0d got=%0d exp=2", c, q[c].size());
      end else if (q[c][0] !== 32'h1000 + 32'(20 + c) || q[c][1] !== 32'h1000 + 32'(24 + c)) begin
        n_fail++;
        $display("FAIL rr_order ch=%0d got=%h,%h exp=%h,%h", c, q[c][0], q[c][1], 32'h1000 + 32'(20 + c), 32'h1000 + 32'(24 + c));
      end
    end
  endtask

  task automatic test_backpressure;
    int g2;
    g2 = 0;
    exp_q.delete();
    q[2].delete();
    for (int a = 30; a < 42; a++) wr(8'(a), 32'h2000 + 32'(a), 4'hf);
    bus.rsp_ready = 4'b1011;
    for (int i = 0; i < 12; i++) begin
      bus.rd_valid = 4'hf;
      for (int c = 0; c < 4; c++) bus.rd_addr[c*8 +: 8] = 8'(c == 2 ? 30 + i : 20 + c);
      mid;
      n_chk++;
      if (!$onehot(bus.rd_ready)) begin n_fail++; $display("FAIL bp_full_rate cyc=%0d got=%b exp=onehot", i, bus.rd_ready); end
      if (bus.rd_ready[2]) begin g2++; exp_q.push_back(32'h2000 + 32'(30 + i)); end
      if (i == 11) begin
        n_chk++;
        if (bus.rd_ready[2] !== 1'b0) begin n_fail++; $display("FAIL bp_stall got=%b exp=0", bus.rd_ready[2]); end
      end
      step;
    end
    n_chk++;
    if (g2 != 3) begin n_fail++; $display("FAIL bp_grants got=%0d exp=3", g2); end
    bus.rd_valid = 4'h0;
    bus.rsp_ready = 4'hf;
    for (int i = 0; i < 6; i++) begin
      mid;
      if (bus.rsp_valid[2]) q[2].push_back(bus.rsp_data[64 +: 32]);
      step;
    end
    n_chk++;
    if (q[2].size() != 3 || exp_q.size() != 3) begin
      n_fail++;
      $display("FAIL bp_drain_count got=%0d exp=3", q[2].size());
    end else if (q[2][0] !== exp_q[0] || q[2][1] !== exp_q[1] || q[2][2] !== exp_q[2]) begin
      n_fail++;
      $display("FAIL bp_drain_order got=%h,%h,%h exp=%h,%h,%h", q[2][0], q[2][1], q[2][2], exp_q[0], exp_q[1], exp_q[2]);
    end
  endtask

  task automatic test_reset_flight;
    logic [31:0] d;
    logic v;
    int g0;
    bus.rsp_ready = 4'b1110;
    bus.rd_valid[0] = 1'b1;
    bus.rd_addr[7:0] = 8'd5;
    step;
    bus.rd_valid[0] = 1'b0;
    bus.rd_valid[1] = 1'b1;
    bus.rd_addr[15:8] = 8'd7;
    step;
    bus.rd_valid[1] = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    bus.rsp_ready = 4'hf;
    mid;
    n_chk++;
    if (bus.rsp_valid !== 4'h0) begin n_fail++; $display("FAIL rst_flight_0 got=%b exp=0000", bus.rsp_valid); end
    step;
    mid;
    n_chk++;
    if (bus.rsp_valid !== 4'h0) begin n_fail++; $display("FAIL rst_flight_1 got=%b exp=0000", bus.rsp_valid); end
    step;
    rd(3, 8'd5, d, v);
    n_chk++;
    if (v !== 1'b1 || d !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rst_next_read got=%b/%h exp=1/a5a5a5a5", v, d); end
    g0 = 0;
    bus.rsp_ready = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      bus.rd_valid[0] = 1'b1;
      bus.rd_addr[7:0] = 8'd5;
      mid;
      if (bus.rd_ready[0]) g0++;
      step;
    end
    bus.rd_valid = 4'h0;
    n_chk++;
    if (g0 != 3) begin n_fail++; $display("FAIL rst_credits got=%0d exp=3", g0); end
    bus.rsp_ready = 4'hf;
    repeat (4) step;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_be = '0;
    bus.rd_valid = '0;
    bus.rd_addr = '0;
    bus.rsp_ready = 4'hf;
    step;
    test_reset;
    test_write_read;
    test_lane_mask;
    test_same_cycle;
    test_w2r;
    test_round_robin;
    test_backpressure;
    test_reset_flight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
